// File: rtl/pipe_reset_sequencer_pkg.sv
// pipe_reset_sequencer_pkg: state encoding and restart counter width (counter only with RSTSEQ_RESTART_CNT_EN)
package pipe_reset_sequencer_pkg;
    typedef enum logic [1:0] {HOLD = 2'd0, RAMP = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_e;
`ifdef RSTSEQ_RESTART_CNT_EN
    localparam int RESTART_CNT_W = 8;
`endif
endpackage

// File: rtl/rstseq_timer.sv
// rstseq_timer: reloadable down-counter that ticks while enabled and at 1
module rstseq_timer #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         tick
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_value : enable ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge CLK) cnt_q <= cnt_d;
    assign tick = enable && cnt_q == W'(1);
endmodule

// File: rtl/pipe_reset_sequencer.sv
// pipe_reset_sequencer: releases stage run enables front to back, drains and re-sequences on restart
// Optional RESTART_CNT output with RSTSEQ_RESTART_CNT_EN.
module pipe_reset_sequencer
    import pipe_reset_sequencer_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int INIT_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RESTART_REQ,
    output logic [N_STAGES-1:0] STAGE_RUN,
    output logic                READY,
    output logic                BUSY,
    output logic                RESTART_ACK
`ifdef RSTSEQ_RESTART_CNT_EN
    ,
    output logic [RESTART_CNT_W-1:0] RESTART_CNT
`endif
);
    localparam int TW = $clog2(INIT_CYCLES > GAP_CYCLES ? INIT_CYCLES : GAP_CYCLES) + 1;
    localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);
    state_e state_q, state_d;
    logic [N_STAGES-1:0] run_q, run_d;
    logic ready_q, busy_q, ack_q, flag_q, flag_d;
    logic accept, enter_run, tick, load;
    logic [TW-1:0] load_value;
    assign accept    = state_q == RUN && RESTART_REQ;
    assign enter_run = state_d == RUN && state_q != RUN;
    assign flag_d    = accept ? 1'b1 : enter_run ? 1'b0 : flag_q;
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            HOLD: if (tick) begin
                run_d   = ONE;
                state_d = N_STAGES == 1 ? RUN : RAMP;
            end
            RAMP: if (tick) begin
                run_d   = (run_q << 1) | ONE;
                state_d = &run_d ? RUN : RAMP;
            end
            RUN: if (RESTART_REQ) begin
                run_d   = run_q & ~ONE;
                state_d = |run_d ? DRAIN : HOLD;
            end
            DRAIN: if (tick) begin
                run_d   = run_q << 1;
                state_d = |run_d ? DRAIN : HOLD;
            end
            default: begin
                run_d   = '0;
                state_d = HOLD;
            end
        endcase
    end
    // every state change reloads the timer with the interval of the state being entered
    assign load       = RST || tick || accept;
    assign load_value = (RST || state_d == HOLD) ? TW'(INIT_CYCLES) : TW'(GAP_CYCLES);
    rstseq_timer #(.W(TW)) u_timer (
        .CLK       (CLK),
        .load      (load),
        .load_value(load_value),
        .enable    (state_q != RUN),
        .tick      (tick)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HOLD;
            run_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            ready_q <= state_d == RUN;
            busy_q  <= state_d != RUN;
            ack_q   <= enter_run && flag_q;
            flag_q  <= flag_d;
        end
    end
    assign STAGE_RUN   = run_q;
    assign READY       = ready_q;
    assign BUSY        = busy_q;
    assign RESTART_ACK = ack_q;
`ifdef RSTSEQ_RESTART_CNT_EN
    logic [RESTART_CNT_W-1:0] cnt_q;
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else if (accept && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
    assign RESTART_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_pipe_reset_sequencer.sv
// tb_pipe_reset_sequencer: two configurations against a time-based reference model (RSTSEQ_RESTART_CNT_EN aware)
module tb_pipe_reset_sequencer;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0;
    logic [4:0] stage_a;
    logic [2:0] stage_b;
    logic ready_a, busy_a, ack_a, ready_b, busy_b, ack_b;
    int errors = 0, checks = 0;
    int ns[2] = '{5, 3};
    int ic[2] = '{1, 4};
    int gc[2] = '{1, 3};
    bit up[2], flag[2];
    int t[2], mcnt[2], acks[2];
    logic [18:0] e_vec[2], a_vec[2];
    logic [4:0] ta[12] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    logic [2:0] tbv[12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7};
    logic [4:0] da[5] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
`ifdef RSTSEQ_RESTART_CNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [7:0] a_cnt[2];
    assign a_cnt[0] = cnt_a;
    assign a_cnt[1] = cnt_b;
`endif

    always #5 clk = ~clk;

    pipe_reset_sequencer dut_a (
        .CLK(clk), .RST(rst), .RESTART_REQ(req), .STAGE_RUN(stage_a),
        .READY(ready_a), .BUSY(busy_a), .RESTART_ACK(ack_a)
`ifdef RSTSEQ_RESTART_CNT_EN
        , .RESTART_CNT(cnt_a)
`endif
    );
    pipe_reset_sequencer #(.N_STAGES(3), .INIT_CYCLES(4), .GAP_CYCLES(3)) dut_b (
        .CLK(clk), .RST(rst), .RESTART_REQ(req), .STAGE_RUN(stage_b),
        .READY(ready_b), .BUSY(busy_b), .RESTART_ACK(ack_b)
`ifdef RSTSEQ_RESTART_CNT_EN
        , .RESTART_CNT(cnt_b)
`endif
    );
    assign a_vec[0] = {11'd0, stage_a, ready_a, busy_a, ack_a};
    assign a_vec[1] = {13'd0, stage_b, ready_b, busy_b, ack_b};

    // Model: time since the sequence (up) or drain (down) began decides every output.
    function automatic void model(int d, logic r, logic q);
        int te, k;
        logic ready, ack;
        logic [15:0] st;
        te = ic[d] + (ns[d] - 1) * gc[d];
        if (r) begin
            up[d] = 1; t[d] = 0; flag[d] = 0; mcnt[d] = 0;
        end else if (up[d] && t[d] >= te && q) begin
            up[d] = ns[d] == 1; t[d] = 0; flag[d] = 1;
            mcnt[d] = mcnt[d] < 255 ? mcnt[d] + 1 : 255;
        end else if (up[d]) begin
            t[d] = t[d] < te ? t[d] + 1 : te;
        end else begin
            t[d]++;
            if (t[d] >= (ns[d] - 1) * gc[d]) begin up[d] = 1; t[d] = 0; end
        end
        if (up[d]) begin
            k = t[d] < ic[d] ? 0 : (t[d] - ic[d]) / gc[d] + 1;
            st = 16'((1 << k) - 1);
            ready = t[d] >= te;
            ack = flag[d] && ready;
            if (ready) flag[d] = 0;
        end else begin
            k = t[d] / gc[d] + 1;
            if (k > ns[d]) k = ns[d];
            st = 16'(((1 << ns[d]) - 1) & ~((1 << k) - 1));
            ready = 0;
            ack = 0;
        end
        e_vec[d] = {st, ready, !ready, ack};
    endfunction

    task automatic cycle(input logic r, input logic q);
        rst = r;
        req = q;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model(d, r, q);
        #1;
        for (int d = 0; d < 2; d++) acks[d] += int'(a_vec[d][0]);
    endtask

    task automatic test_reset();
        repeat (3) cycle(1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (a_vec[d] !== 19'b010) begin
                errors++;
                $display("FAIL reset dut%0d: got %h want %h", d, a_vec[d], 19'b010);
            end
`ifdef RSTSEQ_RESTART_CNT_EN
            checks++;
            if (a_cnt[d] !== 8'd0) begin
                errors++;
                $display("FAIL reset_cnt dut%0d: got %0d want 0", d, a_cnt[d]);
            end
`endif
        end
    endtask

    task automatic test_powerup();
        for (int c = 1; c <= 11; c++) begin
            cycle(1'b0, 1'b0);
            checks += 4;
            if (stage_a !== ta[c]) begin
                errors++;
                $display("FAIL powerup_a c%0d: got %b want %b", c, stage_a, ta[c]);
            end
            if (stage_b !== tbv[c]) begin
                errors++;
                $display("FAIL powerup_b c%0d: got %b want %b", c, stage_b, tbv[c]);
            end
            if ({ready_a, ready_b, busy_a, busy_b} !== {c >= 5, c >= 10, c < 5, c < 10}) begin
                errors++;
                $display("FAIL powerup_flags c%0d: got %b want %b", c, {ready_a, ready_b, busy_a, busy_b},
                         {c >= 5, c >= 10, c < 5, c < 10});
            end
            if ({ack_a, ack_b} !== 2'b00) begin
                errors++;
                $display("FAIL powerup_ack c%0d: got %b want 00", c, {ack_a, ack_b});
            end
        end
    endtask

    task automatic test_restart();
        acks = '{0, 0};
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, i == 0);
            if (i < 5) begin
                checks++;
                if (stage_a !== da[i]) begin
                    errors++;
                    $display("FAIL drain_a i%0d: got %b want %b", i, stage_a, da[i]);
                end
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (a_vec[d] !== e_vec[d]) begin
                    errors++;
                    $display("FAIL restart dut%0d i%0d: got %h want %h", d, i, a_vec[d], e_vec[d]);
                end
            end
        end
        checks++;
        if (acks[0] != 1 || acks[1] != 1) begin
            errors++;
            $display("FAIL restart_ack_count: got %0d/%0d want 1/1", acks[0], acks[1]);
        end
    endtask

    task automatic test_req_during_ramp();
        repeat (3) cycle(1'b1, 1'b0);
        acks = '{0, 0};
        for (int c = 1; c <= 16; c++) begin
            cycle(1'b0, c <= 5);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (a_vec[d] !== e_vec[d]) begin
                    errors++;
                    $display("FAIL ramp_req dut%0d c%0d: got %h want %h", d, c, a_vec[d], e_vec[d]);
                end
            end
        end
        checks++;
        if (acks[0] != 0 || acks[1] != 0 || stage_a !== 5'b11111 || stage_b !== 3'b111) begin
            errors++;
            $display("FAIL ramp_req_final: got ack %0d/%0d stage %b/%b want 0/0 11111/111",
                     acks[0], acks[1], stage_a, stage_b);
        end
    endtask

    task automatic test_reset_mid_drain();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        checks++;
        if (stage_a !== 5'b11100) begin
            errors++;
            $display("FAIL mid_drain_pre: got %b want 11100", stage_a);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if ({stage_a, ready_a, busy_a, ack_a} !== 8'b00000010) begin
            errors++;
            $display("FAIL mid_drain_rst: got %b want 00000010", {stage_a, ready_a, busy_a, ack_a});
        end
`ifdef RSTSEQ_RESTART_CNT_EN
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL mid_drain_cnt: got %0d want 0", cnt_a);
        end
`endif
        acks = '{0, 0};
        for (int c = 1; c <= 16; c++) begin
            cycle(1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (a_vec[d] !== e_vec[d]) begin
                    errors++;
                    $display("FAIL post_rst dut%0d c%0d: got %h want %h", d, c, a_vec[d], e_vec[d]);
                end
            end
        end
        checks++;
        if (acks[0] != 0 || acks[1] != 0) begin
            errors++;
            $display("FAIL post_rst_ack: got %0d/%0d want 0/0", acks[0], acks[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (a_vec[d] !== e_vec[d]) begin
                    errors++;
                    $display("FAIL random dut%0d i%0d: got %h want %h", d, i, a_vec[d], e_vec[d]);
                end
`ifdef RSTSEQ_RESTART_CNT_EN
                checks++;
                if (a_cnt[d] !== 8'(mcnt[d])) begin
                    errors++;
                    $display("FAIL random_cnt dut%0d i%0d: got %0d want %0d", d, i, a_cnt[d], mcnt[d]);
                end
`endif
            end
        end
    endtask

`ifdef RSTSEQ_RESTART_CNT_EN
    task automatic test_saturate();
        repeat (3) cycle(1'b1, 1'b0);
        for (int i = 0; i < 4700; i++) begin
            cycle(1'b0, 1'b1);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (a_vec[d] !== e_vec[d] || a_cnt[d] !== 8'(mcnt[d])) begin
                    errors++;
                    $display("FAIL saturate dut%0d i%0d: got %h/%0d want %h/%0d", d, i,
                             a_vec[d], a_cnt[d], e_vec[d], mcnt[d]);
                end
            end
        end
        checks++;
        if (cnt_a !== 8'd255 || cnt_b !== 8'd255) begin
            errors++;
            $display("FAIL saturate_final: got %0d/%0d want 255/255", cnt_a, cnt_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_restart();
        test_req_during_ramp();
        test_reset_mid_drain();
        test_random();
`ifdef RSTSEQ_RESTART_CNT_EN
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
